// File: rtl/avalon_sdram_arbiter.sv
// Two-host Avalon-MM arbiter in front of the SDRAM controller slave port.
// Round-robin grant with stall lock; read tags route responses in issue order.
module avalon_sdram_arbiter #(
    parameter int AVS_AW          = 24,
    parameter int AVS_DW          = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  h0_read,
    input  logic                  h0_write,
    input  logic [AVS_AW-1:0]     h0_address,
    input  logic [AVS_DW-1:0]     h0_writedata,
    input  logic [AVS_DW/8-1:0]   h0_byteenable,
    output logic                  h0_waitrequest,
    output logic [AVS_DW-1:0]     h0_readdata,
    output logic                  h0_readdatavalid,
    input  logic                  h1_read,
    input  logic                  h1_write,
    input  logic [AVS_AW-1:0]     h1_address,
    input  logic [AVS_DW-1:0]     h1_writedata,
    input  logic [AVS_DW/8-1:0]   h1_byteenable,
    output logic                  h1_waitrequest,
    output logic [AVS_DW-1:0]     h1_readdata,
    output logic                  h1_readdatavalid,
    output logic                  m_read,
    output logic                  m_write,
    output logic [AVS_AW-1:0]     m_address,
    output logic [AVS_DW-1:0]     m_writedata,
    output logic [AVS_DW/8-1:0]   m_byteenable,
    input  logic                  m_waitrequest,
    input  logic [AVS_DW-1:0]     m_readdata,
    input  logic                  m_readdatavalid,
    output logic                  err_orphan
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = PW + 1;

    logic          r_prio;
    logic          r_lock;
    logic          r_lock_id;
    logic          r_err;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          r_tag [MAX_OUTSTANDING];

    logic w_full;
    logic w_empty;
    logic w_rd0;
    logic w_rd1;
    logic w_cand0;
    logic w_cand1;
    logic w_gv;
    logic w_gid;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign w_head  = r_tag[r_rptr];

    // Write wins when a host raises read and write together.
    assign w_rd0   = h0_read & ~h0_write;
    assign w_rd1   = h1_read & ~h1_write;
    assign w_cand0 = (h0_read | h0_write) & ~(w_rd0 & w_full);
    assign w_cand1 = (h1_read | h1_write) & ~(w_rd1 & w_full);

    always_comb begin
        w_gv  = 1'b0;
        w_gid = 1'b0;
        if (reset) begin
            w_gv = 1'b0;
        end else if (r_lock) begin
            w_gv  = 1'b1;
            w_gid = r_lock_id;
        end else if (w_cand0 && w_cand1) begin
            w_gv  = 1'b1;
            w_gid = r_prio;
        end else if (w_cand0) begin
            w_gv  = 1'b1;
        end else if (w_cand1) begin
            w_gv  = 1'b1;
            w_gid = 1'b1;
        end
    end

    assign m_read       = w_gv & (w_gid ? w_rd1 : w_rd0);
    assign m_write      = w_gv & (w_gid ? h1_write : h0_write);
    assign m_address    = w_gid ? h1_address : h0_address;
    assign m_writedata  = w_gid ? h1_writedata : h0_writedata;
    assign m_byteenable = w_gid ? h1_byteenable : h0_byteenable;

    assign w_accept = (m_read | m_write) & ~m_waitrequest;
    assign w_push   = w_accept & m_read;
    assign w_pop    = m_readdatavalid & ~w_empty;

    assign h0_waitrequest = ~(w_gv & ~w_gid & ~m_waitrequest);
    assign h1_waitrequest = ~(w_gv &  w_gid & ~m_waitrequest);

    assign h0_readdata      = m_readdata;
    assign h1_readdata      = m_readdata;
    assign h0_readdatavalid = ~reset & w_pop & ~w_head;
    assign h1_readdatavalid = ~reset & w_pop &  w_head;
    assign err_orphan       = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio    <= 1'b0;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_err     <= 1'b0;
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
        end else begin
            if (w_accept) begin
                r_lock <= 1'b0;
                r_prio <= ~w_gid;
            end else if (m_read | m_write) begin
                // Hold the stalled host's request stable on the master port.
                r_lock    <= 1'b1;
                r_lock_id <= w_gid;
            end
            if (m_readdatavalid && w_empty) begin
                r_err <= 1'b1;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_tag[r_wptr] <= w_gid;
        end
    end
endmodule
